// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences the shared ALU,
// the unified memory and the register file, resolves branches, counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       pc_source_o,
    output logic [3:0]       alu_op_o,
    output logic [3:0]       state_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EX_R   = 4'd2;
    localparam logic [3:0] S_EX_I   = 4'd3;
    localparam logic [3:0] S_MA     = 4'd4;
    localparam logic [3:0] S_MR     = 4'd5;
    localparam logic [3:0] S_MW     = 4'd6;
    localparam logic [3:0] S_WB_ALU = 4'd7;
    localparam logic [3:0] S_WB_MEM = 4'd8;
    localparam logic [3:0] S_BR     = 4'd9;
    localparam logic [3:0] S_JMP    = 4'd10;
    localparam logic [3:0] S_HALT   = 4'd11;

    localparam logic [3:0] ALU_R_TYPE = 4'd0;
    localparam logic [3:0] ALU_ADDI   = 4'd1;
    localparam logic [3:0] ALU_SLTIU  = 4'd2;
    localparam logic [3:0] ALU_BEQ    = 4'd3;
    localparam logic [3:0] ALU_LUI    = 4'd4;
    localparam logic [3:0] ALU_ORI    = 4'd5;
    localparam logic [3:0] ALU_BNE    = 4'd6;

    logic [3:0]       state_q, state_d;
    logic             halt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic       is_rtype, r_ok, is_jr, is_itype, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic [3:0] i_alu_op;

    assign is_rtype = (opcode_i == 6'h00);
    assign is_itype = opcode_i inside {6'h08, 6'h0B, 6'h0F, 6'h0D};
    assign is_lw    = (opcode_i == 6'h23);
    assign is_sw    = (opcode_i == 6'h2B);
    assign is_beq   = (opcode_i == 6'h04);
    assign is_bne   = (opcode_i == 6'h05);
    assign is_j     = (opcode_i == 6'h02);
    assign is_jal   = (opcode_i == 6'h03);

    always_comb begin
        r_ok  = 1'b0;
        is_jr = 1'b0;
        if (is_rtype) begin
            case (funct_i)
                6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h03, 6'h07: r_ok = 1'b1;
                6'h08:                                           is_jr = 1'b1;
                default:                                         ;
            endcase
        end
    end

    always_comb begin
        case (opcode_i)
            6'h0B:   i_alu_op = ALU_SLTIU;
            6'h0F:   i_alu_op = ALU_LUI;
            6'h0D:   i_alu_op = ALU_ORI;
            default: i_alu_op = ALU_ADDI;
        endcase
    end

    // Retirement is flagged on the final cycle of each instruction so the count bumps on the exiting edge.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IF:     if (mem_ready_i) state_d = S_ID;
            S_ID: begin
                if (r_ok)                          state_d = S_EX_R;
                else if (is_jr || is_j || is_jal)  state_d = S_JMP;
                else if (is_itype)                 state_d = S_EX_I;
                else if (is_lw || is_sw)           state_d = S_MA;
                else if (is_beq || is_bne)         state_d = S_BR;
                else                               state_d = S_HALT;
            end
            S_EX_R, S_EX_I: state_d = S_WB_ALU;
            S_MA:     state_d = is_lw ? S_MR : S_MW;
            S_MR:     if (mem_ready_i) state_d = S_WB_MEM;
            S_MW: begin
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BR, S_JMP: begin
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT) halt_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Everything is forced low while reset is held so no write can slip out mid-instruction.
    always_comb begin
        pc_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        pc_source_o  = 2'd0;
        alu_op_o     = ALU_R_TYPE;
        if (rst_i) begin
            case (state_q)
                S_IF: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'd1;
                    alu_op_o    = ALU_ADDI;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_ID: begin
                    alu_src_b_o = 2'd3;
                    alu_op_o    = ALU_ADDI;
                end
                S_EX_R: alu_src_a_o = 1'b1;
                S_EX_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    alu_op_o    = i_alu_op;
                end
                S_WB_ALU: begin
                    reg_write_o = 1'b1;
                    alu_src_a_o = 1'b1;
                    if (is_rtype) begin
                        reg_dst_o = 2'd1;
                    end else begin
                        alu_src_b_o = 2'd2;
                        alu_op_o    = i_alu_op;
                    end
                end
                S_MA: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    alu_op_o    = ALU_ADDI;
                end
                S_MR: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MW: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'd1;
                end
                S_BR: begin
                    alu_src_a_o = 1'b1;
                    pc_source_o = 2'd1;
                    alu_op_o    = is_bne ? ALU_BNE : ALU_BEQ;
                    pc_write_o  = (is_beq & zero_i) | (is_bne & ~zero_i);
                end
                S_JMP: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = is_jr ? 2'd3 : 2'd2;
                    if (is_jal) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = 2'd2;
                        mem_to_reg_o = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o      = state_q;
    assign halt_o       = halt_q;
    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction into
// its expected cycle sequence, and every cycle is compared against the DUT.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, pc_source;
        logic [3:0] alu_op, state;
        logic       halt;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, funct;
        logic       zero, ready;
        ctrl_t      exp;
        logic [3:0] cnt;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_i, zero_i, mem_ready_i;
    logic [5:0] opcode_i, funct_i;
    logic pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, halt;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [3:0] alu_op, state;
    logic [CNT_W-1:0] retire_cnt;
    ctrl_t dut_ctrl;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    cyc_t q[$];
    logic [3:0] model_cnt = '0;
    logic [5:0] cur_op, cur_funct;
    logic cur_zero;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write), .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .pc_source_o(pc_source), .alu_op_o(alu_op), .state_o(state), .halt_o(halt),
        .retire_cnt_o(retire_cnt)
    );

    assign dut_ctrl = {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, state, halt};

    function automatic ctrl_t idle(input logic [3:0] st);
        ctrl_t e;
        e = '0;
        e.state = st;
        e.halt = (st == 4'd11);
        return e;
    endfunction

    task automatic push(input logic rst, input logic ready, input ctrl_t e, input bit retire);
        cyc_t c;
        c.rst = rst; c.op = cur_op; c.funct = cur_funct; c.zero = cur_zero;
        c.ready = ready; c.exp = e; c.cnt = model_cnt;
        q.push_back(c);
        if (retire) model_cnt = model_cnt + 4'd1;
    endtask

    task automatic pushReset();
        model_cnt = '0;
        push(1'b0, 1'b1, idle(4'd0), 1'b0);
    endtask

    task automatic checkOutput(input cyc_t c);
        checks++;
        if (dut_ctrl !== c.exp) begin
            errors++;
            $display("[TB] FAIL ctrl cycle %0d op %h: got %h want %h", cycle_no, c.op, dut_ctrl, c.exp);
        end
        checks++;
        if (retire_cnt !== c.cnt) begin
            errors++;
            $display("[TB] FAIL retire_cnt cycle %0d: got %0d want %0d", cycle_no, retire_cnt, c.cnt);
        end
    endtask

    task automatic checkLiteral(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Called at posedge+1; each record covers one clock period and is compared mid-period.
    task automatic runQueue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_i = c.rst; opcode_i = c.op; funct_i = c.funct;
            zero_i = c.zero; mem_ready_i = c.ready;
            @(negedge clk);
            checkOutput(c);
            cycle_no++;
            @(posedge clk);
            #1;
        end
    endtask

    // Expands one instruction into its expected per-cycle behaviour and runs it.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                                 input int if_wait, input int mem_wait, input int halt_cycles,
                                 input bit rst_mid);
        ctrl_t e;
        bit r_ok, jr, ity, lw, sw, br, jmp;
        logic [3:0] iop;
        cur_op = op; cur_funct = funct; cur_zero = zero;
        r_ok = (op == 6'h00) && (funct inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h03, 6'h07});
        jr   = (op == 6'h00) && (funct == 6'h08);
        ity  = op inside {6'h08, 6'h0B, 6'h0F, 6'h0D};
        lw   = (op == 6'h23);
        sw   = (op == 6'h2B);
        br   = op inside {6'h04, 6'h05};
        jmp  = op inside {6'h02, 6'h03};
        iop  = (op == 6'h0B) ? 4'd2 : (op == 6'h0F) ? 4'd4 : (op == 6'h0D) ? 4'd5 : 4'd1;

        for (int i = 0; i <= if_wait; i++) begin
            e = idle(4'd0); e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_op = 4'd1;
            if (i == if_wait) begin e.ir_write = 1; e.pc_write = 1; end
            push(1'b1, i == if_wait, e, 1'b0);
        end
        e = idle(4'd1); e.alu_src_b = 2'd3; e.alu_op = 4'd1;
        push(1'b1, 1'b0, e, 1'b0);

        if (r_ok || ity) begin
            e = idle(ity ? 4'd3 : 4'd2); e.alu_src_a = 1;
            e.alu_src_b = ity ? 2'd2 : 2'd0; e.alu_op = ity ? iop : 4'd0;
            push(1'b1, 1'b0, e, 1'b0);
            e.state = 4'd7; e.reg_write = 1; e.reg_dst = ity ? 2'd0 : 2'd1;
            push(1'b1, 1'b0, e, 1'b1);
        end else if (lw || sw) begin
            e = idle(4'd4); e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 4'd1;
            push(1'b1, 1'b0, e, 1'b0);
            for (int i = 0; i <= mem_wait; i++) begin
                if (rst_mid && i == 1) begin
                    pushReset();
                    runQueue();
                    return;
                end
                e = idle(lw ? 4'd5 : 4'd6); e.iord = 1;
                if (lw) e.mem_read = 1; else e.mem_write = 1;
                push(1'b1, i == mem_wait, e, sw && i == mem_wait);
            end
            if (lw) begin
                e = idle(4'd8); e.reg_write = 1; e.mem_to_reg = 2'd1;
                push(1'b1, 1'b0, e, 1'b1);
            end
        end else if (br) begin
            e = idle(4'd9); e.alu_src_a = 1; e.pc_source = 2'd1;
            e.alu_op = (op == 6'h04) ? 4'd3 : 4'd6;
            e.pc_write = (op == 6'h04) ? zero : !zero;
            push(1'b1, 1'b0, e, 1'b1);
        end else if (jr || jmp) begin
            e = idle(4'd10); e.pc_write = 1; e.pc_source = jr ? 2'd3 : 2'd2;
            if (op == 6'h03) begin e.reg_write = 1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
            push(1'b1, 1'b0, e, 1'b1);
        end else begin
            for (int i = 0; i < halt_cycles; i++) push(1'b1, 1'b1, idle(4'd11), 1'b0);
        end
        runQueue();
    endtask

    initial begin
        rst_i = 1'b0; opcode_i = 6'h00; funct_i = 6'h21; zero_i = 1'b0; mem_ready_i = 1'b1;
        @(negedge clk);
        checkLiteral("reset_state", {28'd0, state}, 0);
        checkLiteral("reset_mem_read", {31'd0, mem_read}, 0);
        checkLiteral("reset_ir_write", {31'd0, ir_write}, 0);
        checkLiteral("reset_alu_src_b", {30'd0, alu_src_b}, 0);
        checkLiteral("reset_cnt", {28'd0, retire_cnt}, 0);
        @(posedge clk);
        #1;

        applyStimulus(6'h00, 6'h21, 1'b0, 0, 0, 0, 1'b0);
        checkLiteral("cnt_after_addu", {28'd0, retire_cnt}, 1);
        applyStimulus(6'h23, 6'h00, 1'b0, 0, 2, 0, 1'b0);
        checkLiteral("cnt_after_lw", {28'd0, retire_cnt}, 2);
        applyStimulus(6'h04, 6'h00, 1'b1, 0, 0, 0, 1'b0);
        applyStimulus(6'h05, 6'h00, 1'b1, 0, 0, 0, 1'b0);
        applyStimulus(6'h05, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h03, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h00, 6'h08, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h02, 6'h00, 1'b0, 1, 0, 0, 1'b0);
        checkLiteral("cnt_after_jumps", {28'd0, retire_cnt}, 8);
        applyStimulus(6'h08, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h0B, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h0F, 6'h00, 1'b0, 2, 0, 0, 1'b0);
        applyStimulus(6'h00, 6'h03, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h00, 6'h2A, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h2B, 6'h00, 1'b0, 1, 1, 0, 1'b0);
        applyStimulus(6'h00, 6'h07, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h00, 6'h24, 1'b0, 0, 0, 0, 1'b0);
        checkLiteral("cnt_after_mix", {28'd0, retire_cnt}, 0);

        applyStimulus(6'h3F, 6'h00, 1'b0, 0, 0, 10, 1'b0);
        checkLiteral("halt_state", {28'd0, state}, 11);
        checkLiteral("halt_flag", {31'd0, halt}, 1);
        checkLiteral("halt_cnt_frozen", {28'd0, retire_cnt}, 0);
        pushReset();
        runQueue();
        checkLiteral("halt_cleared", {31'd0, halt}, 0);

        for (int i = 0; i < 16; i++) begin
            if (i == 15) checkLiteral("cnt_before_wrap", {28'd0, retire_cnt}, 15);
            applyStimulus(6'h0D, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        end
        checkLiteral("cnt_wrapped", {28'd0, retire_cnt}, 0);

        applyStimulus(6'h00, 6'h20, 1'b0, 0, 0, 2, 1'b0);
        pushReset();
        runQueue();
        applyStimulus(6'h00, 6'h25, 1'b0, 0, 0, 0, 1'b0);
        applyStimulus(6'h2B, 6'h00, 1'b0, 0, 3, 0, 1'b1);
        checkLiteral("cnt_after_mw_reset", {28'd0, retire_cnt}, 0);
        applyStimulus(6'h00, 6'h23, 1'b0, 0, 0, 0, 1'b0);
        checkLiteral("cnt_after_subu", {28'd0, retire_cnt}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
